// File: rtl/io_bus_arbiter.sv
//------------------------------------------------------------------------------
// Module  : io_bus_arbiter
// Purpose : Two-master round-robin arbiter for the SoC peripheral I/O bus
//           (mult, div, uart, dp_ram). Master 0 is the J1 CPU I/O port and
//           master 1 is a secondary master (DMA / debug loader).
//           Each transaction is latched, strobed onto the bus for
//           1+WAIT_CYCLES cycles, then completed with a registered read-data
//           capture and a one-cycle ack to the owning master.
// Ports   :
//   sys_clk_i, sys_rst_i      clock, asynchronous active-low reset
//   m{0,1}_req/wr/addr/wdata  master request side (req held until ack)
//   m{0,1}_gnt/ack            bus ownership flag / completion pulse
//   rdata, err                registered read data / unmapped-access pulse
//   bus_rd, bus_wr            peripheral read / write strobes
//   bus_addr, bus_dout        latched address / write data
//   bus_din                   read data from the selected peripheral
//   cs                        one-hot chip select {mult, div, uart, dp_ram}
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module io_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES  = 1,        // 0..15
  parameter logic [15:0] DEFAULT_DATA = 16'h0666
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  // master 0
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_ack,
  // master 1
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_ack,
  // completion
  output logic [15:0] rdata,
  output logic        err,
  // peripheral bus
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_dout,
  input  logic [15:0] bus_din,
  output logic [3:0]  cs
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit         c_HAS_WAIT  = (WAIT_CYCLES != 0);

  logic [1:0]  r_state;
  logic        r_owner;       // 0 = master 0, 1 = master 1
  logic        r_last_grant;  // owner of the most recently completed transfer
  logic        r_wr;
  logic [15:0] r_bus_addr;
  logic [15:0] r_bus_dout;
  logic [15:0] r_rdata;
  logic [3:0]  r_cnt;

  logic [3:0]  w_decode;
  logic        w_active;
  logic        w_last_strobe;
  logic        w_pick_m1;
  logic        w_any_req;

  // Chip-select decode works from the latched address so a master changing
  // its address mid-transaction cannot disturb the access in flight.
  always_comb begin
    w_decode = 4'b0000;
    case (r_bus_addr[15:8])
      8'h67:   w_decode = 4'b1000;
      8'h68:   w_decode = 4'b0100;
      8'h69:   w_decode = 4'b0010;
      8'h70:   w_decode = 4'b0001;
      default: w_decode = 4'b0000;
    endcase
  end

  assign w_active = (r_state == S_ACCESS) || (r_state == S_WAIT);

  // Final strobe cycle: ACCESS itself when there are no wait cycles,
  // otherwise the WAIT cycle in which the counter has reached 1.
  assign w_last_strobe = ((r_state == S_ACCESS) && !c_HAS_WAIT) ||
                         ((r_state == S_WAIT) && (r_cnt == 4'd1));

  // Master 1 wins when it is the only requester, or on a tie when master 0
  // had the previous grant.
  assign w_any_req = m0_req | m1_req;
  assign w_pick_m1 = m1_req & (~m0_req | ~r_last_grant);

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_wr         <= 1'b0;
      r_bus_addr   <= 16'h0000;
      r_bus_dout   <= 16'h0000;
      r_rdata      <= 16'h0000;
      r_cnt        <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner    <= w_pick_m1;
            r_wr       <= w_pick_m1 ? m1_wr    : m0_wr;
            r_bus_addr <= w_pick_m1 ? m1_addr  : m0_addr;
            r_bus_dout <= w_pick_m1 ? m1_wdata : m0_wdata;
            r_state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_cnt   <= c_WAIT_INIT;
          r_state <= c_HAS_WAIT ? S_WAIT : S_DONE;
        end
        S_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_last_grant <= r_owner;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Read data is sampled at the end of the final strobe cycle; unmapped
      // reads return a recognisable constant instead of a floating bus.
      if (w_last_strobe && !r_wr) begin
        r_rdata <= (w_decode != 4'b0000) ? bus_din : DEFAULT_DATA;
      end
    end
  end

  // Ownership runs from ACCESS through DONE inclusive.
  assign m0_gnt = (r_state != S_IDLE) & ~r_owner;
  assign m1_gnt = (r_state != S_IDLE) &  r_owner;
  assign m0_ack = (r_state == S_DONE) & ~r_owner;
  assign m1_ack = (r_state == S_DONE) &  r_owner;
  assign err    = (r_state == S_DONE) & (w_decode == 4'b0000);

  // Strobes and chip selects decode from registered state only, so an
  // asynchronous reset drops them immediately.
  assign bus_rd   = w_active & ~r_wr;
  assign bus_wr   = w_active &  r_wr;
  assign cs       = w_active ? w_decode : 4'b0000;
  assign bus_addr = r_bus_addr;
  assign bus_dout = r_bus_dout;
  assign rdata    = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_io_bus_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_io_bus_arbiter
// Purpose : Directed self-checking bench for io_bus_arbiter (WAIT_CYCLES=1).
//           Inputs change and outputs are sampled on the falling clock edge.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_io_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_wr = 1'b0;
  logic [15:0] m0_addr = 16'h0, m0_wdata = 16'h0;
  logic        m1_req = 1'b0, m1_wr = 1'b0;
  logic [15:0] m1_addr = 16'h0, m1_wdata = 16'h0;
  logic [15:0] bus_din = 16'h0;
  logic        m0_gnt, m0_ack, m1_gnt, m1_ack, err, bus_rd, bus_wr;
  logic [15:0] rdata, bus_addr, bus_dout;
  logic [3:0]  cs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_bus_arbiter #(
    .WAIT_CYCLES (1),
    .DEFAULT_DATA(16'h0666)
  ) dut (
    .sys_clk_i(clk),
    .sys_rst_i(rst_n),
    .m0_req   (m0_req),
    .m0_wr    (m0_wr),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_gnt   (m0_gnt),
    .m0_ack   (m0_ack),
    .m1_req   (m1_req),
    .m1_wr    (m1_wr),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_gnt   (m1_gnt),
    .m1_ack   (m1_ack),
    .rdata    (rdata),
    .err      (err),
    .bus_rd   (bus_rd),
    .bus_wr   (bus_wr),
    .bus_addr (bus_addr),
    .bus_dout (bus_dout),
    .bus_din  (bus_din),
    .cs       (cs)
  );

  task automatic test_reset;
    int got;
    rst_n = 1'b0;
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 16'h6702;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 16'h6800;
    bus_din = 16'h1111;
    repeat (3) @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt, m0_ack, m1_ack, err, bus_rd, bus_wr, cs} !== 11'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0", {m0_gnt, m1_gnt, m0_ack, m1_ack, err, bus_rd, bus_wr, cs});
    end
    checks++;
    if ({rdata, bus_addr, bus_dout} !== 48'h0) begin
      errors++;
      $display("FAIL reset_data got %h want 0", {rdata, bus_addr, bus_dout});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10 || bus_addr !== 16'h6702) begin
      errors++;
      $display("FAIL reset_first_grant got gnt=%b addr=%h want gnt=10 addr=6702", {m0_gnt, m1_gnt}, bus_addr);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    got = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (m0_ack) begin got = c; break; end
    end
    checks++;
    if (got !== 2) begin
      errors++;
      $display("FAIL reset_first_ack got cycle %0d want 2", got);
    end
  endtask

  task automatic test_read;
    @(negedge clk);
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 16'h6702; bus_din = 16'h1234;
    @(negedge clk);
    checks++;
    if ({bus_rd, bus_wr, cs} !== 6'b10_1000 || m0_gnt !== 1'b1 || bus_addr !== 16'h6702) begin
      errors++;
      $display("FAIL read_access got rd/wr/cs=%b gnt=%b addr=%h want 101000 1 6702", {bus_rd, bus_wr, cs}, m0_gnt, bus_addr);
    end
    @(negedge clk);
    checks++;
    if ({bus_rd, bus_wr, cs} !== 6'b10_1000 || m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL read_wait got rd/wr/cs=%b ack=%b want 101000 0", {bus_rd, bus_wr, cs}, m0_ack);
    end
    @(negedge clk);
    checks++;
    if ({m0_ack, m1_ack, err, bus_rd, cs} !== 8'b100_0_0000 || rdata !== 16'h1234) begin
      errors++;
      $display("FAIL read_done got ack/ack/err/rd/cs=%b rdata=%h want 10000000 1234", {m0_ack, m1_ack, err, bus_rd, cs}, rdata);
    end
    m0_req = 1'b0; bus_din = 16'h0000;
    @(negedge clk);
    checks++;
    if (m0_ack !== 1'b0 || m0_gnt !== 1'b0 || rdata !== 16'h1234) begin
      errors++;
      $display("FAIL read_hold got ack=%b gnt=%b rdata=%h want 0 0 1234", m0_ack, m0_gnt, rdata);
    end
  endtask

  task automatic test_write;
    m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 16'h7005; m1_wdata = 16'hBEEF;
    @(negedge clk);
    checks++;
    if ({bus_rd, bus_wr, cs} !== 6'b01_0001 || bus_dout !== 16'hBEEF || {m0_gnt, m1_gnt} !== 2'b01) begin
      errors++;
      $display("FAIL write_access got rd/wr/cs=%b dout=%h gnt=%b want 010001 beef 01", {bus_rd, bus_wr, cs}, bus_dout, {m0_gnt, m1_gnt});
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({m0_ack, m1_ack, err} !== 3'b010 || rdata !== 16'h1234) begin
      errors++;
      $display("FAIL write_done got ack/ack/err=%b rdata=%h want 010 1234", {m0_ack, m1_ack, err}, rdata);
    end
    m1_req = 1'b0; m1_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int n;
    int last_c;
    logic [3:0] seq;
    logic both;
    n = 0; last_c = 0; seq = 4'b0; both = 1'b0;
    m0_wr = 1'b0; m0_addr = 16'h6900; m1_wr = 1'b0; m1_addr = 16'h6800;
    bus_din = 16'h5A5A;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (m0_ack && m1_ack) both = 1'b1;
      if (m0_ack || m1_ack) begin
        seq[n] = m1_ack;
        n++;
        last_c = c;
        if (n == 4) break;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    checks++;
    if (n !== 4 || last_c !== 15) begin
      errors++;
      $display("FAIL b2b_count got acks=%0d last_cycle=%0d want 4 15", n, last_c);
    end
    checks++;
    if (seq !== 4'b1010) begin
      errors++;
      $display("FAIL b2b_order got %b want 1010 (bit0 first, 1=m1)", seq);
    end
    checks++;
    if (both !== 1'b0) begin
      errors++;
      $display("FAIL b2b_dual_ack got %b want 0", both);
    end
    @(negedge clk);
  endtask

  task automatic test_unmapped;
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 16'h1234; bus_din = 16'hFFFF;
    @(negedge clk);
    checks++;
    if ({bus_rd, bus_wr, cs} !== 6'b10_0000 || bus_addr !== 16'h1234) begin
      errors++;
      $display("FAIL unmapped_access got rd/wr/cs=%b addr=%h want 100000 1234", {bus_rd, bus_wr, cs}, bus_addr);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({m0_ack, err} !== 2'b11 || rdata !== 16'h0666) begin
      errors++;
      $display("FAIL unmapped_done got ack/err=%b rdata=%h want 11 0666", {m0_ack, err}, rdata);
    end
    m0_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({m0_ack, err} !== 2'b00) begin
      errors++;
      $display("FAIL unmapped_pulse got ack/err=%b want 00", {m0_ack, err});
    end
  endtask

  task automatic test_reset_mid;
    int got;
    logic m1_seen;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 16'h6800; bus_din = 16'hCAFE;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({bus_rd, cs, m1_gnt} !== 6'b1_0100_1) begin
      errors++;
      $display("FAIL midrst_wait got rd/cs/gnt=%b want 101001", {bus_rd, cs, m1_gnt});
    end
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 16'h6702;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_rd, bus_wr, cs, m0_gnt, m1_gnt} !== 8'b0) begin
      errors++;
      $display("FAIL midrst_async got rd/wr/cs/gnt=%b want 0", {bus_rd, bus_wr, cs, m0_gnt, m1_gnt});
    end
    @(negedge clk);
    checks++;
    if ({m0_ack, m1_ack} !== 2'b00 || rdata !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_noack got ack=%b rdata=%h want 00 0000", {m0_ack, m1_ack}, rdata);
    end
    m1_req = 1'b0; bus_din = 16'h0BAD;
    rst_n = 1'b1;
    got = 0; m1_seen = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (m1_ack) m1_seen = 1'b1;
      if (m0_ack) begin got = c; break; end
    end
    m0_req = 1'b0;
    checks++;
    if (got !== 3 || m1_seen !== 1'b0) begin
      errors++;
      $display("FAIL midrst_recover got ack_cycle=%0d m1_ack_seen=%b want 3 0", got, m1_seen);
    end
    checks++;
    if (rdata !== 16'h0BAD) begin
      errors++;
      $display("FAIL midrst_rdata got %h want 0bad", rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_unmapped();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
